// File: rtl/dco_freq_meter.sv
// dco_freq_meter: counts rising edges of an asynchronous DCO output over a
// programmable gate window of ((gate_len+1) << GATE_SHIFT) clk cycles.
//   clk      - single clock, all state on its rising edge
//   rst_n    - asynchronous active-low reset
//   ena      - block enable, low forces IDLE and abandons a measurement
//   osc_in   - DCO output, asynchronous to clk, below clk/2
//   gate_len - gate length code, captured when a measurement starts
//   start    - level-sampled measurement request, honoured only in IDLE
//   ready    - consumer acknowledge of the held result
//   busy     - high while measuring
//   valid    - high while a result is held
//   count    - edges counted in the last completed window (saturating)
//   overflow - the edge counter saturated and at least one more edge arrived
module dco_freq_meter #(
  parameter int GATE_SHIFT = 4,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               osc_in,
  input  logic [7:0]         gate_len,
  input  logic               start,
  input  logic               ready,
  output logic               busy,
  output logic               valid,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);
  localparam int GW = 8 + GATE_SHIFT;
  typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;
  state_t             state, state_nx;
  logic               sync1, sync2, hist, osc_edge, sat, ovf_nx;
  logic [GW-1:0]      gate_cnt, gate_nx, gate_load;
  logic [COUNT_W-1:0] edge_cnt, edge_nx, count_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync1, sync2, hist} <= '0;
    else        {sync1, sync2, hist} <= {osc_in, sync1, sync2};
  assign osc_edge = sync2 & ~hist;
  assign sat      = &edge_cnt;
  // Computed one bit wider so gate_len=255 reaches 2^GW before the -1.
  assign gate_load = GW'((((GW+1)'(gate_len) + (GW+1)'(1)) << GATE_SHIFT) - (GW+1)'(1));
  always_comb begin
    state_nx = state;
    gate_nx  = gate_cnt;
    edge_nx  = edge_cnt;
    count_nx = count;
    ovf_nx   = overflow;
    if (!ena) state_nx = IDLE;
    else
      case (state)
        IDLE:
          if (start) begin
            state_nx = MEASURE;
            gate_nx  = gate_load;
            edge_nx  = '0;
            ovf_nx   = 1'b0;
          end
        MEASURE: begin
          edge_nx = edge_cnt + COUNT_W'(osc_edge & ~sat);
          ovf_nx  = overflow | (osc_edge & sat);
          gate_nx = gate_cnt - GW'(1);
          // The gate==0 cycle is the last of the window; its edge is included.
          if (gate_cnt == '0) begin
            state_nx = HOLD;
            gate_nx  = '0;
            count_nx = edge_nx;
          end
        end
        HOLD:    if (ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      gate_cnt <= gate_nx;
      edge_cnt <= edge_nx;
      count    <= count_nx;
      overflow <= ovf_nx;
    end
  assign busy  = (state == MEASURE);
  assign valid = (state == HOLD);
endmodule

// File: doc/dco_freq_meter.md
DCO_FREQ_METER -- requirements
Module: dco_freq_meter

Interface
REQ-001 SHALL have parameter GATE_SHIFT, default 4: gate window length is (gate_len+1) << GATE_SHIFT clk cycles.
REQ-002 SHALL have parameter COUNT_W, default 16: width of the edge count result.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: block enable; low forces idle.
REQ-006 SHALL have port osc_in, input, 1 bit: DCO output under measurement, asynchronous to clk, frequency below clk/2.
REQ-007 SHALL have port gate_len, input, 8 bits: gate length code, latched at start.
REQ-008 SHALL have port start, input, 1 bit: level-sampled request to begin a measurement.
REQ-009 SHALL have port ready, input, 1 bit: consumer acknowledge of the held result.
REQ-010 SHALL have port busy, output, 1 bit: high while in MEASURE.
REQ-011 SHALL have port valid, output, 1 bit: high while a result is held.
REQ-012 SHALL have port count, output, COUNT_W bits: rising edges of osc_in counted in the window.
REQ-013 SHALL have port overflow, output, 1 bit: the edge count saturated.

Function
REQ-014 SHALL pass osc_in through a 2-flop synchronizer plus a history flop; edge = sync2 & ~hist.
- Runs in every state.
- An osc_in rising transition is visible as an edge 3 clk cycles later.
REQ-015 SHALL implement FSM states IDLE, MEASURE, HOLD; reset state IDLE.
REQ-016 IDLE -> MEASURE when ena=1 and start=1 on the same edge; on that edge:
- gate_len latched.
- gate counter loaded with ((gate_len+1) << GATE_SHIFT) - 1.
- edge counter and overflow cleared.
REQ-017 In MEASURE, each cycle SHALL add the edge to the edge counter and decrement the gate counter.
- Window = exactly (gate_len+1) << GATE_SHIFT cycles.
- The edge in the cycle the gate counter is 0 is included.
REQ-018 MEASURE -> HOLD in the cycle after the gate counter reaches 0.
- count = final edge count.
- valid = 1, busy = 0.
REQ-019 The edge counter SHALL saturate at 2^COUNT_W-1.
- An edge arriving while saturated sets overflow = 1.
- overflow stays high until the next start.
REQ-020 In HOLD, count/overflow SHALL be stable; HOLD -> IDLE on the cycle ready=1; valid deasserts the next cycle.
REQ-021 start asserted during MEASURE or HOLD SHALL be ignored; gate_len changes after latching SHALL not affect the running window.
REQ-022 ready in IDLE or MEASURE SHALL have no effect.
REQ-023 If start=1 in the same cycle HOLD is left via ready, the FSM SHALL go to IDLE; a new measurement needs start sampled in IDLE.
REQ-024 ena=0 SHALL synchronously force IDLE, valid=0, busy=0, abandoning any measurement; count retains its last value.
REQ-025 Internal gate counter width SHALL be 8+GATE_SHIFT bits with no wrap-around for gate_len=255.

Reset
REQ-026 rst_n low SHALL immediately, asynchronously, do all of the following:
- state = IDLE.
- busy = 0, valid = 0, overflow = 0, count = 0.
- synchronizer, history, gate and edge counters cleared.
REQ-027 Reset asserted mid-MEASURE or mid-HOLD SHALL discard the measurement; no valid pulse after release.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first clk edge where ena=1 and start=1.

Verification
REQ-029 gate_len=3 (64-cycle window), osc_in period 8 clk free-running at least 8 cycles before start, start pulse -> busy for 64 cycles, then valid=1, count=8, overflow=0.
REQ-030 COUNT_W=8, gate_len=255 (4096 cycles), osc_in period 2 clk -> count=255, overflow=1; next run with osc_in held low -> count=0, overflow=0.
REQ-031 valid=1 with ready held low 100 cycles, start pulsed meanwhile -> count stable, no new measurement; ready=1 -> valid=0 next cycle, state IDLE.
REQ-032 rst_n low for 1 cycle mid-MEASURE -> busy/valid/count=0 immediately; no valid afterward without a new start.
REQ-033 ena dropped mid-MEASURE -> busy=0 next cycle, valid never asserts; count keeps the prior result.
REQ-034 gate_len changed from 3 to 200 during MEASURE -> window stays 64 cycles; next start uses 201<<4 = 3216 cycles.
